fire_alarm_ctrl: RTL and testbench



---
 rtl/fire_alarm_pkg.sv | 14 +
 rtl/fire_alarm_ctrl_zone_confirm.sv | 34 +++
 rtl/fire_alarm_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fire_alarm_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fire_alarm_pkg.sv
// Shared definitions for the multi-zone fire alarm controller:
// panel state encoding and the width of the alarmState port.
package fire_alarm_pkg;

  localparam int ALARM_STATE_W = 2;

  typedef enum logic [ALARM_STATE_W-1:0] {
    IDLE     = 2'd0,
    PREALARM = 2'd1,
    ALARM    = 2'd2,
    SILENCED = 2'd3
  } alarm_state_t;

endpackage

// File: rtl/fire_alarm_ctrl_zone_confirm.sv
// Per-zone detector debounce: a saturating run-length counter of
// consecutive high samples; the zone is confirmed while the counter
// sits at CONFIRM_CYCLES.
module zone_confirm #(
  parameter int CONFIRM_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic confirmed
);

  localparam int CNT_W = (CONFIRM_CYCLES < 1) ? 1 : $clog2(CONFIRM_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONFIRM_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Count consecutive high samples, saturate at the confirm length, drop to 0 on any low sample
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!level) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Confirmed flag is combinational on the counter
  always_comb begin
    confirmed = (cnt == CNT_MAX);
  end

endmodule

// File: rtl/fire_alarm_ctrl.sv
// Multi-zone fire alarm controller: per-zone debounce, voting, a
// pre-alarm/alarm/silenced state machine with escalation and re-sound
// timers, and a sticky per-zone latch for the panel.
// Optional visual strobe output enabled by defining FIRE_ALARM_STROBE_EN.
module fire_alarm_ctrl
  import fire_alarm_pkg::*;
#(
  parameter int ZONES           = 3,
  parameter int VOTE            = 2,
  parameter int CONFIRM_CYCLES  = 4,
  parameter int ESCALATE_CYCLES = 32,
  parameter int SILENCE_CYCLES  = 16
`ifdef FIRE_ALARM_STROBE_EN
  ,
  parameter int STROBE_HALF     = 8
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ZONES-1:0]         smoke_detector,
  input  logic                     ack,
  input  logic                     clear,
  output logic                     alarmEnable,
  output logic                     preAlarm,
  output logic [ZONES-1:0]         zoneLatch,
  output logic [ALARM_STATE_W-1:0] alarmState
`ifdef FIRE_ALARM_STROBE_EN
  ,
  output logic                     strobe
`endif
);

  localparam int NC_W  = $clog2(ZONES + 1);
  localparam int ESC_W = (ESCALATE_CYCLES < 1) ? 1 : $clog2(ESCALATE_CYCLES + 1);
  localparam int SIL_W = (SILENCE_CYCLES < 1) ? 1 : $clog2(SILENCE_CYCLES + 1);

  localparam logic [NC_W-1:0]  VOTE_N   = NC_W'(VOTE);
  localparam logic [ESC_W-1:0] ESC_LAST = ESC_W'(ESCALATE_CYCLES - 1);
  localparam logic [SIL_W-1:0] SIL_LOAD = SIL_W'(SILENCE_CYCLES - 1);

  alarm_state_t     state;
  alarm_state_t     next_state;
  logic [ZONES-1:0] confirmed;
  logic [NC_W-1:0]  n_conf;
  logic [ESC_W-1:0] esc_cnt;
  logic [SIL_W-1:0] sil_cnt;
  logic             vote_met;
  logic             any_conf;
  logic             new_zone;
  logic             esc_done;
  logic             sil_done;
  logic             clear_accept;

  for (genvar z = 0; z < ZONES; z++) begin : g_zone
    zone_confirm #(
      .CONFIRM_CYCLES(CONFIRM_CYCLES)
    ) u_zone_confirm (
      .clk      (clk),
      .reset    (reset),
      .level    (smoke_detector[z]),
      .confirmed(confirmed[z])
    );
  end

  // Count confirmed zones and derive the transition conditions
  always_comb begin
    n_conf = '0;
    for (int unsigned i = 0; i < ZONES; i++) begin
      n_conf = n_conf + NC_W'(confirmed[i]);
    end
    vote_met     = (n_conf >= VOTE_N);
    any_conf     = (n_conf != '0);
    new_zone     = |(confirmed & ~zoneLatch);
    esc_done     = (esc_cnt == ESC_LAST);
    sil_done     = (sil_cnt == '0);
    clear_accept = clear && !any_conf && ((state == ALARM) || (state == SILENCED));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; accepted clear outranks ack, ack outranks timers and votes
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (vote_met) begin
          next_state = ALARM;
        end else if (any_conf) begin
          next_state = PREALARM;
        end
      end
      PREALARM: begin
        if (vote_met || esc_done) begin
          next_state = ALARM;
        end else if (!any_conf) begin
          next_state = IDLE;
        end
      end
      ALARM: begin
        if (clear_accept) begin
          next_state = IDLE;
        end else if (ack) begin
          next_state = SILENCED;
        end
      end
      SILENCED: begin
        if (clear_accept) begin
          next_state = IDLE;
        end else if (new_zone || sil_done) begin
          next_state = ALARM;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    alarmEnable = (state == ALARM);
    preAlarm    = (state == PREALARM);
    alarmState  = state;
  end

  // Escalation timer: held at 0 outside PREALARM so it restarts on every entry
  always_ff @(posedge clk) begin
    if (reset || (state != PREALARM)) begin
      esc_cnt <= '0;
    end else if (!esc_done) begin
      esc_cnt <= esc_cnt + 1'b1;
    end
  end

  // Silence timer: loaded on ack out of ALARM, counts down while SILENCED
  always_ff @(posedge clk) begin
    if (reset) begin
      sil_cnt <= '0;
    end else if ((state == ALARM) && (next_state == SILENCED)) begin
      sil_cnt <= SIL_LOAD;
    end else if ((state == SILENCED) && !sil_done) begin
      sil_cnt <= sil_cnt - 1'b1;
    end
  end

  // Sticky record of every zone that has been confirmed since the last accepted clear
  always_ff @(posedge clk) begin
    if (reset || clear_accept) begin
      zoneLatch <= '0;
    end else begin
      zoneLatch <= zoneLatch | confirmed;
    end
  end

`ifdef FIRE_ALARM_STROBE_EN
  localparam int STB_W = (STROBE_HALF < 1) ? 1 : $clog2(STROBE_HALF + 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STROBE_HALF - 1);

  logic [STB_W-1:0] stb_cnt;

  // Strobe square wave while sounding; entry edge sees the previous non-ALARM state, so it starts low
  always_ff @(posedge clk) begin
    if (reset || (state != ALARM)) begin
      stb_cnt <= '0;
      strobe  <= 1'b0;
    end else if (stb_cnt == STB_LAST) begin
      stb_cnt <= '0;
      strobe  <= ~strobe;
    end else begin
      stb_cnt <= stb_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fire_alarm_ctrl.sv
// Self-checking bench for fire_alarm_ctrl: directed scenarios followed by
// randomized stimulus, every cycle compared against a behavioural model.
// Strobe is checked when FIRE_ALARM_STROBE_EN is defined.
module tb_fire_alarm_ctrl;

  localparam int ZONES = 3;
  localparam int VOTE  = 2;
  localparam int CONF  = 4;
  localparam int ESC   = 32;
  localparam int SIL   = 16;
  localparam int HALF  = 8;

  localparam int M_IDLE = 0;
  localparam int M_PRE  = 1;
  localparam int M_ALM  = 2;
  localparam int M_SIL  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [ZONES-1:0] smoke;
  logic             ack;
  logic             clear;
  logic             alarmEnable;
  logic             preAlarm;
  logic [ZONES-1:0] zoneLatch;
  logic [1:0]       alarmState;
`ifdef FIRE_ALARM_STROBE_EN
  logic             strobe;
`endif

  always #5 clk = ~clk;

  fire_alarm_ctrl #(
    .ZONES          (ZONES),
    .VOTE           (VOTE),
    .CONFIRM_CYCLES (CONF),
    .ESCALATE_CYCLES(ESC),
    .SILENCE_CYCLES (SIL)
`ifdef FIRE_ALARM_STROBE_EN
    ,
    .STROBE_HALF    (HALF)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .smoke_detector(smoke),
    .ack           (ack),
    .clear         (clear),
    .alarmEnable   (alarmEnable),
    .preAlarm      (preAlarm),
    .zoneLatch     (zoneLatch),
    .alarmState    (alarmState)
`ifdef FIRE_ALARM_STROBE_EN
    ,
    .strobe        (strobe)
`endif
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Behavioural model: run lengths of high samples and edge timestamps of state entries
  int               m_state = M_IDLE;
  int               run[ZONES];
  bit [ZONES-1:0]   m_latch = '0;
  int               t = 0;
  int               pre_entry = 0;
  int               sil_entry = 0;
  int               alm_entry = 0;

  task automatic model_step(input bit rst, input bit [ZONES-1:0] sm, input bit a, input bit c);
    bit [ZONES-1:0] conf;
    int n;
    int ns;
    bit cleared;
    t++;
    if (rst) begin
      m_state = M_IDLE;
      m_latch = '0;
      for (int z = 0; z < ZONES; z++) run[z] = 0;
      return;
    end
    n = 0;
    for (int z = 0; z < ZONES; z++) begin
      conf[z] = (run[z] >= CONF);
      if (conf[z]) n++;
    end
    ns = m_state;
    cleared = 1'b0;
    case (m_state)
      M_IDLE: begin
        if (n >= VOTE) ns = M_ALM;
        else if (n >= 1) ns = M_PRE;
      end
      M_PRE: begin
        if (n >= VOTE || (t - pre_entry) >= ESC) ns = M_ALM;
        else if (n == 0) ns = M_IDLE;
      end
      M_ALM: begin
        if (c && n == 0) begin ns = M_IDLE; cleared = 1'b1; end
        else if (a) ns = M_SIL;
      end
      default: begin
        if (c && n == 0) begin ns = M_IDLE; cleared = 1'b1; end
        else if ((conf & ~m_latch) != '0 || (t - sil_entry) >= SIL) ns = M_ALM;
      end
    endcase
    if (ns != m_state) begin
      if (ns == M_PRE) pre_entry = t;
      if (ns == M_SIL) sil_entry = t;
      if (ns == M_ALM) alm_entry = t;
    end
    m_state = ns;
    m_latch = cleared ? '0 : (m_latch | conf);
    for (int z = 0; z < ZONES; z++) run[z] = sm[z] ? run[z] + 1 : 0;
  endtask

  task automatic cycle(input bit rst, input bit [ZONES-1:0] sm, input bit a, input bit c);
    reset = rst;
    smoke = sm;
    ack   = a;
    clear = c;
    @(posedge clk);
    model_step(rst, sm, a, c);
    #1;
    check_eq("alarmState", 32'(alarmState), 32'(m_state));
    check_eq("alarmEnable", 32'(alarmEnable), 32'(m_state == M_ALM));
    check_eq("preAlarm", 32'(preAlarm), 32'(m_state == M_PRE));
    check_eq("zoneLatch", 32'(zoneLatch), 32'(m_latch));
`ifdef FIRE_ALARM_STROBE_EN
    check_eq("strobe", 32'(strobe), (m_state == M_ALM) ? 32'(((t - alm_entry) / HALF) % 2) : 32'd0);
`endif
  endtask

  initial begin
    bit [ZONES-1:0] mask;
    bit [ZONES-1:0] sm;
    int len;
    int sel;
    for (int z = 0; z < ZONES; z++) run[z] = 0;
    reset = 1'b1;
    smoke = '0;
    ack   = 1'b0;
    clear = 1'b0;
    #2;

    // Reset state
    cycle(1, '0, 0, 0);
    cycle(1, '0, 0, 0);

    // Two-zone vote, silence, re-sound
    repeat (6) cycle(0, 3'b011, 0, 0);
    cycle(0, 3'b011, 1, 0);
    repeat (17) cycle(0, 3'b011, 0, 0);
    // Clear while still confirmed, then with inputs low
    cycle(0, 3'b011, 0, 1);
    cycle(0, 3'b000, 0, 0);
    cycle(0, 3'b000, 0, 1);
    cycle(0, 3'b000, 0, 0);

    // Glitch on zone 2, then held zone 2 escalates
    repeat (3) cycle(0, 3'b100, 0, 0);
    repeat (2) cycle(0, 3'b000, 0, 0);
    repeat (40) cycle(0, 3'b100, 0, 0);

    // Silence, then a new zone confirms during silence
    cycle(0, 3'b100, 1, 0);
    repeat (6) cycle(0, 3'b101, 0, 0);

    // Ack and clear together: confirmed zones keep it silenced
    cycle(0, 3'b101, 1, 1);
    repeat (20) cycle(0, 3'b101, 0, 0);

    // Reset mid-alarm
    cycle(1, 3'b101, 0, 0);
    cycle(0, 3'b000, 0, 0);

    // Ack and clear together with nothing confirmed goes to IDLE
    repeat (6) cycle(0, 3'b110, 0, 0);
    cycle(0, 3'b000, 0, 0);
    cycle(0, 3'b000, 1, 1);
    cycle(0, 3'b000, 0, 0);

    // Randomized segments
    for (int seg = 0; seg < 120; seg++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: mask = '0;
        1: begin mask = '0; mask[$urandom_range(0, ZONES - 1)] = 1'b1; end
        2: mask = ZONES'($urandom);
        default: mask = '1;
      endcase
      len = $urandom_range(1, 50);
      for (int i = 0; i < len; i++) begin
        sm = mask;
        if ($urandom_range(0, 15) == 0) begin
          int idx;
          idx = $urandom_range(0, ZONES - 1);
          sm[idx] = ~sm[idx];
        end
        cycle(($urandom_range(0, 299) == 0), sm,
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
